// File: rtl/rename_stage.sv
// Register rename stage: speculative/retirement RATs plus a bitmap free list, one instruction per cycle.
// Optional RENAME_STATS_EN adds accepted-instruction and stall-cycle counters.
module rename_stage #(
   parameter int MAX_OPERANDS = 3,
   parameter int ARN_BITS     = 6,
   parameter int PRN_BITS     = 7,
   parameter int FU_COUNT     = 4,
   parameter int FUC_BITS     = $clog2(FU_COUNT),
   parameter int ZERO_ARN     = 31
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                input_valid,
   output logic                input_ready,
   input  logic [31:0]         raw_instr,
   input  logic [63:0]         instr_pc,
   input  logic [FUC_BITS-1:0] fu_choice,
   input  logic [ARN_BITS-1:0] arn_inputs  [MAX_OPERANDS],
   input  logic [ARN_BITS-1:0] arn_outputs [MAX_OPERANDS],
   output logic                output_valid,
   input  logic                output_ready,
   output logic [31:0]         out_raw_instr,
   output logic [63:0]         out_instr_pc,
   output logic [FUC_BITS-1:0] out_fu_choice,
   output logic [PRN_BITS-1:0] prn_inputs  [MAX_OPERANDS],
   output logic [PRN_BITS-1:0] prn_outputs [MAX_OPERANDS],
   output logic [PRN_BITS-1:0] prn_prev    [MAX_OPERANDS],
   input  logic                commit_valid,
   input  logic [ARN_BITS-1:0] commit_arn,
   input  logic [PRN_BITS-1:0] commit_prn,
   input  logic [PRN_BITS-1:0] commit_prev_prn,
   input  logic                flush,
   output logic [31:0]         stat_renamed,
   output logic [31:0]         stat_stall
);
   localparam int NUM_ARN = 1 << ARN_BITS;
   localparam int NUM_PRN = 1 << PRN_BITS;
   localparam int CNT_W   = PRN_BITS + 1;
   localparam logic [ARN_BITS-1:0] ZERO_A = ARN_BITS'(ZERO_ARN);
   localparam logic [PRN_BITS-1:0] ZERO_P = PRN_BITS'(ZERO_ARN);

   logic [PRN_BITS-1:0] spec_rat_q   [NUM_ARN];
   logic [PRN_BITS-1:0] spec_rat_d   [NUM_ARN];
   logic [PRN_BITS-1:0] retire_rat_q [NUM_ARN];
   logic [PRN_BITS-1:0] retire_rat_d [NUM_ARN];
   logic [NUM_PRN-1:0]  free_q, free_d, used_q, used_d;

   logic                out_valid_q, out_valid_d;
   logic [31:0]         out_raw_q, out_raw_d;
   logic [63:0]         out_pc_q, out_pc_d;
   logic [FUC_BITS-1:0] out_fu_q, out_fu_d;
   logic [PRN_BITS-1:0] prn_in_q   [MAX_OPERANDS];
   logic [PRN_BITS-1:0] prn_in_d   [MAX_OPERANDS];
   logic [PRN_BITS-1:0] prn_out_q  [MAX_OPERANDS];
   logic [PRN_BITS-1:0] prn_out_d  [MAX_OPERANDS];
   logic [PRN_BITS-1:0] prn_prev_q [MAX_OPERANDS];
   logic [PRN_BITS-1:0] prn_prev_d [MAX_OPERANDS];

   logic [CNT_W-1:0]    free_count, needed;
   logic                accept;
   logic [NUM_PRN-1:0]  free_alloc;
   logic [PRN_BITS-1:0] rat_tmp  [NUM_ARN];
   logic [PRN_BITS-1:0] ren_src  [MAX_OPERANDS];
   logic [PRN_BITS-1:0] ren_new  [MAX_OPERANDS];
   logic [PRN_BITS-1:0] ren_prev [MAX_OPERANDS];

   always_comb begin
      free_count = '0;
      for (int j = 0; j < NUM_PRN; j++) free_count = free_count + CNT_W'(free_q[j]);
      needed = '0;
      for (int i = 0; i < MAX_OPERANDS; i++)
         if (arn_outputs[i] != ZERO_A) needed = needed + CNT_W'(1);
      input_ready = !rst && !flush && (!out_valid_q || output_ready) && (free_count >= needed);
      accept      = input_valid && input_ready;
   end

   // Slots allocate in index order from a running copy of the free map and RAT,
   // so duplicate destinations chain their previous mappings naturally.
   always_comb begin
      logic [PRN_BITS-1:0] alloc;
      logic                found;
      alloc      = '0;
      found      = 1'b0;
      free_alloc = free_q;
      rat_tmp    = spec_rat_q;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
         ren_src[i] = spec_rat_q[arn_inputs[i]];
         if (arn_outputs[i] == ZERO_A) begin
            ren_new[i]  = ZERO_P;
            ren_prev[i] = ZERO_P;
         end else begin
            ren_prev[i] = rat_tmp[arn_outputs[i]];
            alloc = '0;
            found = 1'b0;
            for (int j = 0; j < NUM_PRN; j++) begin
               if (!found && free_alloc[j]) begin
                  alloc = PRN_BITS'(j);
                  found = 1'b1;
               end
            end
            if (found) free_alloc[alloc] = 1'b0;
            rat_tmp[arn_outputs[i]] = alloc;
            ren_new[i] = alloc;
         end
      end
   end

   always_comb begin
      spec_rat_d   = spec_rat_q;
      retire_rat_d = retire_rat_q;
      free_d       = free_q;
      used_d       = used_q;
      out_valid_d  = out_valid_q;
      out_raw_d    = out_raw_q;
      out_pc_d     = out_pc_q;
      out_fu_d     = out_fu_q;
      prn_in_d     = prn_in_q;
      prn_out_d    = prn_out_q;
      prn_prev_d   = prn_prev_q;
      if (accept) begin
         spec_rat_d  = rat_tmp;
         free_d      = free_alloc;
         out_valid_d = 1'b1;
         out_raw_d   = raw_instr;
         out_pc_d    = instr_pc;
         out_fu_d    = fu_choice;
         prn_in_d    = ren_src;
         prn_out_d   = ren_new;
         prn_prev_d  = ren_prev;
      end else if (output_ready) begin
         out_valid_d = 1'b0;
      end
      // A freed PRN lands in free_d only, so it is never visible to this cycle's allocation.
      if (commit_valid) begin
         retire_rat_d[commit_arn] = commit_prn;
         if (commit_prev_prn != ZERO_P) free_d[commit_prev_prn] = 1'b1;
         used_d[commit_prev_prn] = 1'b0;
         used_d[commit_prn]      = 1'b1;
      end
      if (flush) begin
         out_valid_d    = 1'b0;
         spec_rat_d     = retire_rat_d;
         free_d         = ~used_d;
         free_d[ZERO_P] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < NUM_ARN; a++) begin
            spec_rat_q[a]   <= PRN_BITS'(a);
            retire_rat_q[a] <= PRN_BITS'(a);
         end
         for (int j = 0; j < NUM_PRN; j++) begin
            free_q[j] <= (j >= NUM_ARN) && (j != ZERO_ARN);
            used_q[j] <= (j < NUM_ARN);
         end
         out_valid_q <= 1'b0;
         out_raw_q   <= '0;
         out_pc_q    <= '0;
         out_fu_q    <= '0;
         for (int i = 0; i < MAX_OPERANDS; i++) begin
            prn_in_q[i]   <= '0;
            prn_out_q[i]  <= '0;
            prn_prev_q[i] <= '0;
         end
      end else begin
         spec_rat_q   <= spec_rat_d;
         retire_rat_q <= retire_rat_d;
         free_q       <= free_d;
         used_q       <= used_d;
         out_valid_q  <= out_valid_d;
         out_raw_q    <= out_raw_d;
         out_pc_q     <= out_pc_d;
         out_fu_q     <= out_fu_d;
         prn_in_q     <= prn_in_d;
         prn_out_q    <= prn_out_d;
         prn_prev_q   <= prn_prev_d;
      end
   end

   assign output_valid  = out_valid_q;
   assign out_raw_instr = out_raw_q;
   assign out_instr_pc  = out_pc_q;
   assign out_fu_choice = out_fu_q;
   assign prn_inputs    = prn_in_q;
   assign prn_outputs   = prn_out_q;
   assign prn_prev      = prn_prev_q;

`ifdef RENAME_STATS_EN
   logic [31:0] stat_renamed_q, stat_renamed_d, stat_stall_q, stat_stall_d;

   always_comb begin
      stat_renamed_d = stat_renamed_q + 32'(accept);
      stat_stall_d   = stat_stall_q + 32'(input_valid && !input_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_renamed_q <= '0;
         stat_stall_q   <= '0;
      end else begin
         stat_renamed_q <= stat_renamed_d;
         stat_stall_q   <= stat_stall_d;
      end
   end

   assign stat_renamed = stat_renamed_q;
   assign stat_stall   = stat_stall_q;
`else
   assign stat_renamed = '0;
   assign stat_stall   = '0;
`endif
endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: reset, renaming, duplicates, stalls, free-list exhaustion, flush, stats.
module tb_rename_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        input_valid = 1'b0;
   logic        input_ready;
   logic [31:0] raw_instr = '0;
   logic [63:0] instr_pc = '0;
   logic [1:0]  fu_choice = '0;
   logic [5:0]  arn_in  [3];
   logic [5:0]  arn_out [3];
   logic        output_valid;
   logic        output_ready = 1'b1;
   logic [31:0] out_raw_instr;
   logic [63:0] out_instr_pc;
   logic [1:0]  out_fu_choice;
   logic [6:0]  prn_in   [3];
   logic [6:0]  prn_out  [3];
   logic [6:0]  prn_prv  [3];
   logic        commit_valid = 1'b0;
   logic [5:0]  commit_arn = '0;
   logic [6:0]  commit_prn = '0;
   logic [6:0]  commit_prev_prn = '0;
   logic        flush = 1'b0;
   logic [31:0] stat_renamed, stat_stall;

   int checks = 0;
   int errors = 0;

   rename_stage dut (
      .clk(clk), .rst(rst),
      .input_valid(input_valid), .input_ready(input_ready),
      .raw_instr(raw_instr), .instr_pc(instr_pc), .fu_choice(fu_choice),
      .arn_inputs(arn_in), .arn_outputs(arn_out),
      .output_valid(output_valid), .output_ready(output_ready),
      .out_raw_instr(out_raw_instr), .out_instr_pc(out_instr_pc), .out_fu_choice(out_fu_choice),
      .prn_inputs(prn_in), .prn_outputs(prn_out), .prn_prev(prn_prv),
      .commit_valid(commit_valid), .commit_arn(commit_arn), .commit_prn(commit_prn),
      .commit_prev_prn(commit_prev_prn), .flush(flush),
      .stat_renamed(stat_renamed), .stat_stall(stat_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [5:0] o0, o1, o2, i0, i1, i2);
      arn_out[0] = o0; arn_out[1] = o1; arn_out[2] = o2;
      arn_in[0]  = i0; arn_in[1]  = i1; arn_in[2]  = i2;
   endtask

   task automatic chk_ren(input string tag, input logic [6:0] s0, s1, s2, n0, n1, n2, p0, p1, p2);
      chk({tag, ".valid"}, output_valid, 1);
      chk({tag, ".src0"}, prn_in[0], s0);
      chk({tag, ".src1"}, prn_in[1], s1);
      chk({tag, ".src2"}, prn_in[2], s2);
      chk({tag, ".dst0"}, prn_out[0], n0);
      chk({tag, ".dst1"}, prn_out[1], n1);
      chk({tag, ".dst2"}, prn_out[2], n2);
      chk({tag, ".prev0"}, prn_prv[0], p0);
      chk({tag, ".prev1"}, prn_prv[1], p1);
      chk({tag, ".prev2"}, prn_prv[2], p2);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      input_valid = 1'b0;
      commit_valid = 1'b0;
      flush = 1'b0;
      output_ready = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   initial begin
      instr(31, 31, 31, 31, 31, 31);
      #1 rst = 1'b1;
      #1;
      chk("rst.out_valid", output_valid, 0);
      chk("rst.dst0", prn_out[0], 0);
      chk("rst.prev0", prn_prv[0], 0);
      chk("rst.src0", prn_in[0], 0);
      chk("rst.pc", out_instr_pc, 0);
      chk("rst.raw", out_raw_instr, 0);
      chk("rst.stat_renamed", stat_renamed, 0);
      chk("rst.stat_stall", stat_stall, 0);
      input_valid = 1'b1;
      #1;
      chk("rst.in_ready", input_ready, 0);
      input_valid = 1'b0;
      tick;
      tick;
      rst = 1'b0;

      // first instruction after reset
      instr(0, 31, 31, 1, 2, 31);
      raw_instr = 32'hDEADBEEF; instr_pc = 64'h1000; fu_choice = 2'd2;
      input_valid = 1'b1;
      #1 chk("t1.in_ready", input_ready, 1);
      tick;
      chk_ren("t1", 1, 2, 31, 64, 31, 31, 0, 31, 31);
      chk("t1.raw", out_raw_instr, 32'hDEADBEEF);
      chk("t1.pc", out_instr_pc, 64'h1000);
      chk("t1.fu", out_fu_choice, 2);

      // asynchronous reset drops the pending instruction without a handshake
      input_valid = 1'b0;
      output_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst.out_valid", output_valid, 0);
      chk("arst.dst0", prn_out[0], 0);
      chk("arst.raw", out_raw_instr, 0);
      tick;
      tick;
      rst = 1'b0;
      output_ready = 1'b1;

      // back-to-back writes of ARN 5, duplicate destinations, dependent reads
      instr(5, 31, 31, 31, 31, 31);
      input_valid = 1'b1;
      tick;
      chk_ren("w5a", 31, 31, 31, 64, 31, 31, 5, 31, 31);
      tick;
      chk_ren("w5b", 31, 31, 31, 65, 31, 31, 64, 31, 31);
      instr(31, 31, 31, 5, 31, 31);
      tick;
      chk_ren("r5", 65, 31, 31, 31, 31, 31, 31, 31, 31);
      instr(9, 9, 31, 31, 31, 31);
      tick;
      chk_ren("dup9", 31, 31, 31, 66, 67, 31, 9, 66, 31);
      instr(31, 31, 31, 9, 5, 0);
      tick;
      chk_ren("r9", 67, 65, 0, 31, 31, 31, 31, 31, 31);

      // downstream backpressure holds outputs and blocks allocation
      output_ready = 1'b0;
      instr(1, 31, 31, 31, 31, 31);
      #1 chk("hold.in_ready", input_ready, 0);
      tick;
      chk_ren("hold", 67, 65, 0, 31, 31, 31, 31, 31, 31);
      chk("hold.in_ready2", input_ready, 0);
      output_ready = 1'b1;
      #1 chk("rel.in_ready", input_ready, 1);
      tick;
      chk_ren("rel", 31, 31, 31, 68, 31, 31, 1, 31, 31);
      input_valid = 1'b0;
      tick;
      chk("drain.out_valid", output_valid, 0);

      // exhaust the free list
      do_reset;
      for (int k = 0; k < 21; k++) begin
         instr(1, 2, 3, 31, 31, 31);
         input_valid = 1'b1;
         #1 chk("ex.in_ready", input_ready, 1);
         tick;
         chk("ex.dst0", prn_out[0], 64 + 3 * k);
         chk("ex.dst2", prn_out[2], 66 + 3 * k);
      end
      instr(1, 2, 3, 31, 31, 31);
      #1 chk("ex.partial_ready", input_ready, 0);
      instr(4, 31, 31, 31, 31, 31);
      #1 chk("ex.last_ready", input_ready, 1);
      tick;
      chk("ex.last_dst", prn_out[0], 127);
      chk("ex.last_prev", prn_prv[0], 4);
      chk("ex.empty_ready", input_ready, 0);
      commit_valid = 1'b1; commit_arn = 6'd3; commit_prn = 7'd66; commit_prev_prn = 7'd3;
      #1 chk("ex.nobypass_ready", input_ready, 0);
      tick;
      commit_valid = 1'b0;
      #1 chk("ex.freed_ready", input_ready, 1);
      tick;
      chk("ex.freed_valid", output_valid, 1);
      chk("ex.freed_dst", prn_out[0], 3);
      chk("ex.freed_prev", prn_prv[0], 127);
      input_valid = 1'b0;
      tick;

      // commit then flush restores the retirement mapping
      do_reset;
      instr(7, 31, 31, 31, 31, 31);
      input_valid = 1'b1;
      tick;
      chk_ren("fl.w7a", 31, 31, 31, 64, 31, 31, 7, 31, 31);
      commit_valid = 1'b1; commit_arn = 6'd7; commit_prn = 7'd64; commit_prev_prn = 7'd7;
      #1 chk("fl.ready", input_ready, 1);
      tick;
      chk_ren("fl.w7b", 31, 31, 31, 65, 31, 31, 64, 31, 31);
      commit_valid = 1'b0;
      flush = 1'b1;
      instr(8, 31, 31, 7, 31, 31);
      #1 chk("fl.flush_ready", input_ready, 0);
      tick;
      chk("fl.out_valid", output_valid, 0);
      flush = 1'b0;
      #1 chk("fl.post_ready", input_ready, 1);
      tick;
      chk_ren("fl.r7", 64, 31, 31, 7, 31, 31, 8, 31, 31);
      instr(8, 31, 31, 31, 31, 31);
      tick;
      chk_ren("fl.w8", 31, 31, 31, 65, 31, 31, 7, 31, 31);
      input_valid = 1'b0;
      tick;

      // statistics: 3 accepts and 2 stalled cycles
      do_reset;
      instr(31, 31, 31, 1, 31, 31);
      input_valid = 1'b1;
      tick;
      output_ready = 1'b0;
      tick;
      tick;
      output_ready = 1'b1;
      tick;
      tick;
      input_valid = 1'b0;
      tick;
`ifdef RENAME_STATS_EN
      chk("stat.renamed", stat_renamed, 3);
      chk("stat.stall", stat_stall, 2);
`else
      chk("stat.renamed", stat_renamed, 0);
      chk("stat.stall", stat_stall, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
